// File: rtl/div_sub_datapath_ctrl.sv
// -----------------------------------------------------------------------------
// div_sub_datapath_ctrl
//
// Unsigned integer divider built from repeated subtraction. It is the inverse
// companion of the repeated-addition multiplier datapath. The dividend and the
// divisor arrive one after the other on a shared bus. An FSM loads the two
// operands, runs one subtract/count iteration per cycle, and then hands off
// the registered result with a one-cycle done pulse.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   start      in   request a new division; sampled only in IDLE
//   data_in    in   [WIDTH] operand bus: dividend first, then divisor
//   data_valid in   data_in carries an operand this cycle
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse; results are valid from this cycle on
//   quotient   out  [WIDTH] registered quotient (all ones on divide-by-zero)
//   remainder  out  [WIDTH] registered remainder (dividend on divide-by-zero)
//   rem_zero   out  registered, remainder == 0
//   div_zero   out  registered, last operation had divisor 0
// -----------------------------------------------------------------------------
module div_sub_datapath_ctrl #(
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             rem_zero,
    output logic             div_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_A,
        S_LD_B,
        S_CALC,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Working registers: A is the running dividend/remainder, B the divisor,
    // Q the iteration count that becomes the quotient.
    logic [WIDTH-1:0] a_q, b_q, q_q;

    // Subtraction is only allowed when it cannot underflow.
    logic a_ge_b;
    assign a_ge_b = (a_q >= b_q);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start)      state_d = S_LD_A;
            S_LD_A: if (data_valid) state_d = S_LD_B;
            S_LD_B: if (data_valid) state_d = (data_in == '0) ? S_DONE : S_CALC;
            S_CALC: if (!a_ge_b)    state_d = S_DONE;
            S_DONE:                 state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State, datapath and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            q_q       <= '0;
            quotient  <= '0;
            remainder <= '0;
            rem_zero  <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_IDLE: begin
                    // div_zero describes the previous operation until a new
                    // one is actually accepted.
                    if (start) div_zero <= 1'b0;
                end
                S_LD_A: begin
                    if (data_valid) a_q <= data_in;
                end
                S_LD_B: begin
                    if (data_valid) begin
                        if (data_in != '0) begin
                            b_q <= data_in;
                            q_q <= '0;
                        end else begin
                            // Divide-by-zero skips the loop entirely.
                            quotient  <= '1;
                            remainder <= a_q;
                            rem_zero  <= (a_q == '0);
                            div_zero  <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    if (a_ge_b) begin
                        a_q <= a_q - b_q;
                        q_q <= q_q + 1'b1;
                    end else begin
                        quotient  <= q_q;
                        remainder <= a_q;
                        rem_zero  <= (a_q == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    // Both flags decode straight from the state register, so they are
    // glitch-free and line up with the result registers.
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

endmodule

// File: doc/div_sub_datapath_ctrl.md
Name: div_sub_datapath_ctrl

Overview:
- Integer divider using repeated subtraction. It is the inverse companion of the team's repeated-addition multiplier datapath.
- Dividend and divisor arrive serially over a shared WIDTH-bit input bus.
- An internal FSM sequences operand loading, the subtract/count loop and result hand-off.
- Results are registered and held, with a one-cycle done pulse for the downstream consumer.

Parameters:
- WIDTH, 15, width of the data bus, dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new division; sampled only in IDLE.
- data_in  input  WIDTH  shared operand bus; carries the dividend first, then the divisor.
- data_valid  input  1  data_in holds an operand this cycle.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle on.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.
- rem_zero  output  1  registered; high when remainder equals 0.
- div_zero  output  1  registered; last operation had divisor 0.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, internal A/B/Q=0, busy=0, done=0, quotient=0, remainder=0, rem_zero=0, div_zero=0. Reset overrides all other inputs and aborts any operation in progress.
- State IDLE:
  - start=1 → LD_A, and div_zero is cleared.
  - data_valid in IDLE is ignored, including in the same cycle as start.
- State LD_A:
  - Holds until data_valid=1.
  - On data_valid: A<=data_in → LD_B.
- State LD_B:
  - Holds until data_valid=1.
  - On data_valid with data_in!=0: B<=data_in, Q<=0 → CALC.
  - On data_valid with data_in==0: quotient<=all ones, remainder<=A, rem_zero<=(A==0), div_zero<=1 → DONE.
- State CALC, one iteration per cycle:
  - If A>=B: A<=A-B, Q<=Q+1, stay in CALC.
  - Else: quotient<=Q, remainder<=A, rem_zero<=(A==0) → DONE.
- State DONE: done=1 for exactly this cycle, then → IDLE unconditionally.
- start is ignored outside IDLE; it is never queued.
- data_valid outside LD_A/LD_B is ignored.
- Arithmetic:
  - Unsigned WIDTH-bit.
  - A>=B is checked before subtracting, so A never underflows.
  - Q cannot overflow, because the maximum iteration count is 2^WIDTH-1 (divisor 1).
- Latency: divisor accepted at cycle t, quotient N → done=1 at cycle t+N+2. Divide-by-zero → done=1 at t+1.
- Result outputs change only on the edge entering DONE or on reset. They hold between operations, including while the next operands load.
- div_zero is held until the next accepted start or reset.

Test Plan:
- Dividend 100, divisor 7, data_valid back-to-back → done at t+16, quotient=14, remainder=2, rem_zero=0, div_zero=0.
- Dividend 5, divisor 9 → done at t+2, quotient=0, remainder=5. The previous result is held until that edge.
- Dividend 32767, divisor 1 → done at t+32769, quotient=32767, remainder=0, rem_zero=1.
- Dividend 12, divisor 0 → done at t+1, div_zero=1, quotient=0x7FFF, remainder=12. The next start clears div_zero.
- data_valid low for 5 cycles in LD_A and 3 cycles in LD_B → state holds, busy=1, no load occurs. Result is as if no gaps, shifted by 8 cycles.
- start pulsed during CALC → ignored. Then rst mid-CALC → next cycle busy=0 and all outputs 0. Then 20/4 → quotient=5, remainder=0, rem_zero=1.
